// File: rtl/sync_fifo_reader.sv
// Drain-side adapter for sync_fifo: turns the FIFO pop interface (one-cycle SRAM read latency)
// into a registered valid/ready stream, using a 2-entry skid buffer for full throughput.
module sync_fifo_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  fifo_read_en,
    input  logic                  flush,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic                  busy
);

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [CNT_WIDTH-1:0]  beat_q;
    logic                  fire;
    logic                  capture;
    logic                  head_nxt;
    logic [2:0]            level;

    assign m_valid    = (occ_q != 2'd0);
    assign m_data     = m_data_q;
    assign beat_count = beat_q;
    assign busy       = (occ_q != 2'd0) | inflight_q;

    assign fire     = m_valid & m_ready & ~flush;
    // A word arriving during flush is dropped along with the buffer contents.
    assign capture  = inflight_q & ~flush;
    assign head_nxt = ~head_q;
    assign level    = {1'b0, occ_q} + {2'b00, inflight_q};

    // occ + inflight - fire < 2, rearranged to stay unsigned.
    assign fifo_read_en = rst_n & ~fifo_empty & ~flush & (level < (3'd2 + {2'b00, fire}));

    always_comb begin
        occ_d    = occ_q;
        head_d   = head_q;
        tail_d   = tail_q;
        m_data_d = m_data_q;
        if (flush) begin
            occ_d  = 2'd0;
            head_d = 1'b0;
            tail_d = 1'b0;
        end else begin
            if (capture) begin
                tail_d = ~tail_q;
            end
            if (fire) begin
                head_d = ~head_q;
            end
            occ_d = occ_q + {1'b0, capture} - {1'b0, fire};
            // Precompute the next head word so m_data comes straight from a flop.
            if (fire && occ_q == 2'd2) begin
                m_data_d = mem_q[head_nxt];
            end else if (capture && (occ_q == 2'd0 || fire)) begin
                m_data_d = fifo_read_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            m_data_q   <= '0;
            beat_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_read_en;
            head_q     <= head_d;
            tail_q     <= tail_d;
            m_data_q   <= m_data_d;
            if (fire) begin
                beat_q <= beat_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (capture) begin
            mem_q[tail_q] <= fifo_read_data;
        end
    end

endmodule
